// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory port scheduler.
//   - default requester / port counts and bus widths
//   - REQ_IDX_W: width of a requester index
//   - issue_t: one port's issue record {valid, req_idx}
package mem_sched_pkg;

  localparam int unsigned REQ_COUNT_DEF  = 4;
  localparam int unsigned PORT_COUNT_DEF = 2;
  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned MEM_WIDTH_DEF  = 12;

  // $clog2 that never returns 0, so single-entry indices still get one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_IDX_W = clog2_min1(REQ_COUNT_DEF);

  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] req_idx;
  } issue_t;

endpackage

// File: rtl/rr_port_allocator.sv
// Combinational round-robin allocator: maps up to PORT_COUNT pending requests onto RAM ports.
// Ports:
//   i_rr_ptr       first requester to consider this cycle
//   i_req_valid    per-requester pending flag
//   i_req_write    per-requester write flag
//   i_req_addr     packed per-requester word address
//   o_port_issue   per-port {valid, requester index}, port 0 filled first
//   o_req_ready    per-requester grant
//   o_rr_ptr_next  pointer for the next cycle (last grant + 1, or unchanged)
module rr_port_allocator
  import mem_sched_pkg::*;
#(
  parameter int unsigned REQ_COUNT  = REQ_COUNT_DEF,
  parameter int unsigned PORT_COUNT = PORT_COUNT_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [REQ_IDX_W-1:0]            i_rr_ptr,
  input  logic [REQ_COUNT-1:0]            i_req_valid,
  input  logic [REQ_COUNT-1:0]            i_req_write,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] i_req_addr,
  output issue_t [PORT_COUNT-1:0]         o_port_issue,
  output logic [REQ_COUNT-1:0]            o_req_ready,
  output logic [REQ_IDX_W-1:0]            o_rr_ptr_next
);

  localparam int unsigned PortCntW = clog2_min1(PORT_COUNT + 1);
  localparam int unsigned PortIdxW = clog2_min1(PORT_COUNT);
  localparam logic [REQ_IDX_W:0]   ReqCountW  = (REQ_IDX_W + 1)'(REQ_COUNT);
  localparam logic [PortCntW-1:0]  PortCountW = PortCntW'(PORT_COUNT);
  localparam logic [REQ_IDX_W-1:0] LastReq    = REQ_IDX_W'(REQ_COUNT - 1);

  logic [ADDR_WIDTH-1:0] w_addr [REQ_COUNT];

  for (genvar r = 0; r < REQ_COUNT; r++) begin : g_unpack
    assign w_addr[r] = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [REQ_COUNT-1:0] w_grant;
  logic [PortCntW-1:0]  w_used;
  logic [REQ_IDX_W:0]   w_sum;
  logic [REQ_IDX_W-1:0] w_cand;
  logic [REQ_IDX_W-1:0] w_last;
  logic                 w_any;
  logic                 w_hazard;

  always_comb begin
    w_grant      = '0;
    o_port_issue = '0;
    w_used       = '0;
    w_sum        = '0;
    w_cand       = '0;
    w_last       = '0;
    w_any        = 1'b0;
    w_hazard     = 1'b0;
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      // Candidate = (rr_ptr + k) mod REQ_COUNT; both terms < REQ_COUNT so one wrap suffices.
      w_sum = {1'b0, i_rr_ptr} + (REQ_IDX_W + 1)'(k);
      if (w_sum >= ReqCountW) begin
        w_sum = w_sum - ReqCountW;
      end
      w_cand = w_sum[REQ_IDX_W-1:0];

      // A write may not share an address with anything else issued this cycle.
      w_hazard = 1'b0;
      for (int unsigned j = 0; j < REQ_COUNT; j++) begin
        if (w_grant[j] && (w_addr[j] == w_addr[w_cand]) &&
            (i_req_write[j] || i_req_write[w_cand])) begin
          w_hazard = 1'b1;
        end
      end

      if (i_req_valid[w_cand] && !w_hazard && (w_used < PortCountW)) begin
        w_grant[w_cand]                      = 1'b1;
        o_port_issue[w_used[PortIdxW-1:0]]   = '{valid: 1'b1, req_idx: w_cand};
        w_used                               = w_used + PortCntW'(1);
        w_last                               = w_cand;
        w_any                                = 1'b1;
      end
    end
  end

  assign o_req_ready = w_grant;

  always_comb begin
    o_rr_ptr_next = i_rr_ptr;
    if (w_any) begin
      o_rr_ptr_next = (w_last == LastReq) ? '0 : w_last + REQ_IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Schedules REQ_COUNT requesters onto the PORT_COUNT ports of a multiport RAM with a
// one-cycle registered read, returning each result to its requester two cycles after grant.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req_valid/write        per-requester request and direction
//   i_req_addr/wdata         packed per-requester address and write data
//   o_req_ready              per-requester grant (combinational on the request inputs)
//   o_resp_valid/data        one-cycle response strobe and data (read data or written data)
//   o_ram_address/datain     packed per-port RAM address and write data
//   o_ram_mem_write          per-port RAM write enable
//   i_ram_dataout            packed per-port RAM read data (valid the cycle after grant)
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned REQ_COUNT  = REQ_COUNT_DEF,
  parameter int unsigned PORT_COUNT = PORT_COUNT_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_WIDTH  = MEM_WIDTH_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [REQ_COUNT-1:0]            i_req_valid,
  input  logic [REQ_COUNT-1:0]            i_req_write,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [REQ_COUNT*MEM_WIDTH-1:0]  i_req_wdata,
  output logic [REQ_COUNT-1:0]            o_req_ready,
  output logic [REQ_COUNT-1:0]            o_resp_valid,
  output logic [REQ_COUNT*MEM_WIDTH-1:0]  o_resp_data,
  output logic [PORT_COUNT*ADDR_WIDTH-1:0] o_ram_address,
  output logic [PORT_COUNT*MEM_WIDTH-1:0] o_ram_datain,
  output logic [PORT_COUNT-1:0]           o_ram_mem_write,
  input  logic [PORT_COUNT*MEM_WIDTH-1:0] i_ram_dataout
);

  logic [REQ_IDX_W-1:0]           r_rr_ptr;
  issue_t [PORT_COUNT-1:0]        r_issue;
  logic [REQ_COUNT-1:0]           r_resp_valid;
  logic [REQ_COUNT*MEM_WIDTH-1:0] r_resp_data;

  issue_t [PORT_COUNT-1:0]        w_alloc_issue;
  issue_t [PORT_COUNT-1:0]        w_port_issue;
  logic [REQ_COUNT-1:0]           w_alloc_ready;
  logic [REQ_IDX_W-1:0]           w_rr_ptr_next;
  logic [REQ_COUNT-1:0]           w_resp_valid_d;
  logic [REQ_COUNT*MEM_WIDTH-1:0] w_resp_data_d;

  rr_port_allocator #(
    .REQ_COUNT  (REQ_COUNT),
    .PORT_COUNT (PORT_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_alloc (
    .i_rr_ptr      (r_rr_ptr),
    .i_req_valid   (i_req_valid),
    .i_req_write   (i_req_write),
    .i_req_addr    (i_req_addr),
    .o_port_issue  (w_alloc_issue),
    .o_req_ready   (w_alloc_ready),
    .o_rr_ptr_next (w_rr_ptr_next)
  );

  // While reset is low nothing is granted and every port is idle.
  always_comb begin
    w_port_issue = w_alloc_issue;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      w_port_issue[p].valid = w_alloc_issue[p].valid & i_rst_n;
    end
  end

  assign o_req_ready = w_alloc_ready & {REQ_COUNT{i_rst_n}};

  // Route each granted requester's address/data/direction onto its port; idle ports read 0.
  always_comb begin
    o_ram_address   = '0;
    o_ram_datain    = '0;
    o_ram_mem_write = '0;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      for (int unsigned r = 0; r < REQ_COUNT; r++) begin
        if (w_port_issue[p].valid && (w_port_issue[p].req_idx == REQ_IDX_W'(r))) begin
          o_ram_address[p*ADDR_WIDTH +: ADDR_WIDTH] = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
          o_ram_datain[p*MEM_WIDTH +: MEM_WIDTH]    = i_req_wdata[r*MEM_WIDTH +: MEM_WIDTH];
          o_ram_mem_write[p]                        = i_req_write[r];
        end
      end
    end
  end

  // One cycle after issue the RAM output belongs to the recorded requester. A requester is
  // granted at most once per cycle, so at most one port matches each requester.
  always_comb begin
    w_resp_valid_d = '0;
    w_resp_data_d  = r_resp_data;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      for (int unsigned r = 0; r < REQ_COUNT; r++) begin
        if (r_issue[p].valid && (r_issue[p].req_idx == REQ_IDX_W'(r))) begin
          w_resp_valid_d[r]                       = 1'b1;
          w_resp_data_d[r*MEM_WIDTH +: MEM_WIDTH] = i_ram_dataout[p*MEM_WIDTH +: MEM_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_issue      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_rr_ptr     <= w_rr_ptr_next;
      r_issue      <= w_port_issue;
      r_resp_valid <= w_resp_valid_d;
      r_resp_data  <= w_resp_data_d;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_port_scheduler.sv
module tb_mem_port_scheduler;

  localparam int RQ = 4;
  localparam int PC = 2;
  localparam int AW = 12;
  localparam int MW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RQ-1:0]    req_valid, req_write, req_ready, resp_valid;
  logic [RQ*AW-1:0] req_addr;
  logic [RQ*MW-1:0] req_wdata, resp_data;
  logic [PC*AW-1:0] ram_address;
  logic [PC*MW-1:0] ram_datain, ram_dataout;
  logic [PC-1:0]    ram_mem_write;

  // Requester-side state driven by the stimulus.
  logic [RQ-1:0] d_valid;
  logic [RQ-1:0] d_write;
  logic [AW-1:0] d_addr  [RQ];
  logic [MW-1:0] d_wdata [RQ];

  assign req_valid = d_valid;
  assign req_write = d_write;
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int r = 0; r < RQ; r++) begin
      req_addr[r*AW +: AW]  = d_addr[r];
      req_wdata[r*MW +: MW] = d_wdata[r];
    end
  end

  mem_port_scheduler #(
    .REQ_COUNT  (RQ),
    .PORT_COUNT (PC),
    .ADDR_WIDTH (AW),
    .MEM_WIDTH  (MW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .i_req_write     (req_write),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_req_ready     (req_ready),
    .o_resp_valid    (resp_valid),
    .o_resp_data     (resp_data),
    .o_ram_address   (ram_address),
    .o_ram_datain    (ram_datain),
    .o_ram_mem_write (ram_mem_write),
    .i_ram_dataout   (ram_dataout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] init_val(input int a);
    if (a == 'h010) return 12'hABC;
    return 12'((a * 37) + 341);
  endfunction

  // Multiport RAM: write-first, one-cycle registered read.
  logic [MW-1:0] ram_mem [4096];
  initial begin
    for (int a = 0; a < 4096; a++) ram_mem[a] = init_val(a);
    ram_dataout = '0;
    forever begin
      @(posedge clk);
      for (int p = 0; p < PC; p++)
        if (ram_mem_write[p]) ram_mem[ram_address[p*AW +: AW]] = ram_datain[p*MW +: MW];
      for (int p = 0; p < PC; p++)
        ram_dataout[p*MW +: MW] <= ram_mem[ram_address[p*AW +: AW]];
    end
  end

  // Reference model and the per-cycle compare, at the falling edge.
  int            m_ptr;
  logic [RQ-1:0] m_grant;
  logic [RQ-1:0] m_s1v, m_s2v;
  logic [MW-1:0] m_s1d [RQ];
  logic [MW-1:0] m_s2d [RQ];
  logic [MW-1:0] shadow [4096];

  initial begin
    for (int a = 0; a < 4096; a++) shadow[a] = init_val(a);
    m_ptr = 0; m_grant = '0; m_s1v = '0; m_s2v = '0;
    forever begin : cmp
      int q[$];
      int r;
      bit ok;
      logic [RQ-1:0]    exp_ready;
      logic [PC*AW-1:0] ea;
      logic [PC*MW-1:0] ed;
      logic [PC-1:0]    ew;
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready", req_ready, '0);
        chk("rst_mem_write", ram_mem_write, '0);
        chk("rst_resp_valid", resp_valid, '0);
        m_ptr = 0; m_grant = '0; m_s1v = '0; m_s2v = '0;
      end else begin
        q = {};
        for (int k = 0; k < RQ; k++) begin
          r  = (m_ptr + k) % RQ;
          ok = d_valid[r] && (q.size() < PC);
          foreach (q[i])
            if (d_addr[q[i]] == d_addr[r] && (d_write[q[i]] || d_write[r])) ok = 0;
          if (ok) q.push_back(r);
        end
        exp_ready = '0; ea = '0; ed = '0; ew = '0;
        foreach (q[i]) begin
          exp_ready[q[i]] = 1'b1;
          ea[i*AW +: AW]  = d_addr[q[i]];
          ed[i*MW +: MW]  = d_wdata[q[i]];
          ew[i]           = d_write[q[i]];
        end
        chk("req_ready", req_ready, exp_ready);
        chk("ram_address", ram_address, ea);
        chk("ram_datain", ram_datain, ed);
        chk("ram_mem_write", ram_mem_write, ew);
        chk("resp_valid", resp_valid, m_s2v);
        for (int i = 0; i < RQ; i++)
          if (m_s2v[i]) chk("resp_data", resp_data[i*MW +: MW], m_s2d[i]);
        m_s2v = m_s1v; m_s2d = m_s1d; m_s1v = '0;
        foreach (q[i]) if (d_write[q[i]]) shadow[d_addr[q[i]]] = d_wdata[q[i]];
        foreach (q[i]) begin
          m_s1v[q[i]] = 1'b1;
          m_s1d[q[i]] = d_write[q[i]] ? d_wdata[q[i]] : shadow[d_addr[q[i]]];
        end
        if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % RQ;
        m_grant = exp_ready;
      end
    end
  end

  // Advance one clock; granted requesters drop their request unless keep is set.
  task automatic tick(input bit keep);
    @(posedge clk); #1;
    if (!keep) for (int r = 0; r < RQ; r++) if (m_grant[r]) d_valid[r] = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; d_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input bit w, input int a, input int d);
    d_valid[r] = 1'b1; d_write[r] = w; d_addr[r] = AW'(a); d_wdata[r] = MW'(d);
  endtask

  int cnt [RQ];
  int unfair;
  int mx, mn;

  initial begin
    d_valid = '0; d_write = '0;
    for (int r = 0; r < RQ; r++) begin d_addr[r] = '0; d_wdata[r] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read.
    do_reset();
    set_req(2, 0, 'h010, 0);
    mid(); chk("single_ready", req_ready, 4'b0100);
    chk("single_addr", ram_address, 24'h000010);
    tick(0); mid(); chk("single_t1_novalid", resp_valid, 4'b0000);
    tick(0); mid(); chk("single_t2_valid", resp_valid, 4'b0100);
    chk("single_t2_data", resp_data[2*MW +: MW], 12'hABC);
    tick(0); mid(); chk("single_t3_novalid", resp_valid, 4'b0000);
    tick(0);

    // Four simultaneous reads.
    do_reset();
    for (int r = 0; r < RQ; r++) set_req(r, 0, r + 1, 0);
    mid(); chk("four_c1_ready", req_ready, 4'b0011);
    chk("four_c1_addr", ram_address, 24'h002001);
    tick(0); mid(); chk("four_c2_ready", req_ready, 4'b1100);
    chk("four_c2_addr", ram_address, 24'h004003);
    tick(0); mid(); chk("four_c3_valid", resp_valid, 4'b0011);
    chk("four_c3_d0", resp_data[0 +: MW], init_val(1));
    chk("four_c3_d1", resp_data[MW +: MW], init_val(2));
    tick(0); mid(); chk("four_c4_valid", resp_valid, 4'b1100);
    chk("four_c4_d3", resp_data[3*MW +: MW], init_val(4));
    tick(0);

    // Write/read hazard on one address.
    do_reset();
    set_req(0, 1, 'h020, 'h5A5);
    set_req(1, 0, 'h020, 0);
    mid(); chk("haz_c1_ready", req_ready, 4'b0001);
    chk("haz_c1_we", ram_mem_write, 2'b01);
    tick(0); mid(); chk("haz_c2_ready", req_ready, 4'b0010);
    tick(0); mid(); chk("haz_c3_valid", resp_valid, 4'b0001);
    chk("haz_c3_d0", resp_data[0 +: MW], 12'h5A5);
    tick(0); mid(); chk("haz_c4_valid", resp_valid, 4'b0010);
    chk("haz_c4_d1", resp_data[MW +: MW], 12'h5A5);
    tick(0);

    // Same-address reads.
    do_reset();
    set_req(1, 0, 'h030, 0);
    set_req(3, 0, 'h030, 0);
    mid(); chk("same_ready", req_ready, 4'b1010);
    tick(0); tick(0); mid();
    chk("same_valid", resp_valid, 4'b1010);
    chk("same_d1", resp_data[MW +: MW], init_val('h030));
    chk("same_d3", resp_data[3*MW +: MW], init_val('h030));
    tick(0);

    // Fairness under continuous demand.
    do_reset();
    for (int r = 0; r < RQ; r++) begin set_req(r, 0, 'h100 + r, 0); cnt[r] = 0; end
    unfair = 0;
    for (int c = 0; c < 8; c++) begin
      mid();
      for (int r = 0; r < RQ; r++) if (req_ready[r]) cnt[r]++;
      mx = cnt[0]; mn = cnt[0];
      for (int r = 1; r < RQ; r++) begin
        if (cnt[r] > mx) mx = cnt[r];
        if (cnt[r] < mn) mn = cnt[r];
      end
      if (mx - mn > 1) unfair++;
      tick(1);
    end
    d_valid = '0;
    for (int r = 0; r < RQ; r++) chk($sformatf("fair_cnt%0d", r), 64'(cnt[r]), 64'd4);
    chk("fair_order", 64'(unfair), 64'd0);
    repeat (3) tick(0);

    // Reset while a read is in flight.
    do_reset();
    set_req(0, 0, 'h040, 0);
    mid(); chk("rstmf_ready", req_ready, 4'b0001);
    tick(0);
    rst_n = 1'b0;
    set_req(0, 0, 'h040, 0);
    set_req(1, 1, 'h050, 'h7FF);
    set_req(2, 0, 'h060, 0);
    set_req(3, 0, 'h070, 0);
    mid(); chk("rstmf_we", ram_mem_write, 2'b00);
    chk("rstmf_ready0", req_ready, 4'b0000);
    chk("rstmf_t1_valid", resp_valid, 4'b0000);
    chk("rstmf_data", resp_data, '0);
    tick(0); mid(); chk("rstmf_t2_valid", resp_valid, 4'b0000);
    tick(0); rst_n = 1'b1;
    mid(); chk("rstmf_ptr0", req_ready, 4'b0011);
    tick(0); d_valid = '0;
    repeat (3) tick(0);

    // Randomized traffic on a small address range to provoke hazards.
    for (int c = 0; c < 2000; c++) begin
      tick(0);
      if (c == 1000) begin
        rst_n = 1'b0;
        tick(0); tick(0);
        rst_n = 1'b1;
      end
      for (int r = 0; r < RQ; r++) begin
        if (!d_valid[r] && $urandom_range(0, 3) != 0)
          set_req(r, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
      end
    end
    tick(0); d_valid = '0;
    repeat (4) tick(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
